// File: rtl/fpmul_bus_master.sv
// fpmul_bus_master
//   Initiator for the FP-multiplier wrapper register bus. It accepts an operand
//   pair on a valid/ready request port, then writes A, writes B, sets GO, polls
//   DONE, reads RESULT and clears GO. The product is returned on a valid/ready
//   response port.
//
//   Register map: wr 00=A, wr 01=B, wr 10=CTRL(bit0 GO);
//                 rd 00=STATUS(bit0 DONE), rd 01=RESULT, rd 10=CTRL.
//
//   Optional feature macro: FPMUL_MASTER_TIMEOUT_EN
//     defined   : abort after POLL_TIMEOUT polls without DONE, then respond with
//                 rsp_err=1 and rsp_data=0.
//     undefined : POLL waits indefinitely and rsp_err is tied to 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_a/req_b are the operands
//   rsp_valid/rsp_ready   response handshake; rsp_data is the product,
//                         rsp_err flags a timeout abort
//   bus_we/bus_addr/      registered register-bus outputs
//   bus_wdata
//   bus_rdata             read data, combinational from bus_addr
module fpmul_bus_master #(
  parameter int DATA_W       = 32,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bus_we,
  output logic [1:0]        bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_GO,
    S_POLL,
    S_RD_RES,
    S_CLR_GO,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_b;
  logic [CNT_W-1:0]  r_poll_cnt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_bus_we;
  logic [1:0]        r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              w_bus_we;
  logic [1:0]        w_bus_addr;
  logic [DATA_W-1:0] w_bus_wdata;
  logic              w_done;
  logic              w_timeout;

  assign w_done = bus_rdata[0];

`ifdef FPMUL_MASTER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_TIMEOUT - 1);
  logic r_rsp_err;

  // The poll currently on the bus is the POLL_TIMEOUT-th one when the count
  // of earlier polls has reached POLL_TIMEOUT-1.
  assign w_timeout = (r_state == S_POLL) && !w_done && (r_poll_cnt >= POLL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_WR_A;
      S_WR_A:   w_state_nxt = S_WR_B;
      S_WR_B:   w_state_nxt = S_WR_GO;
      S_WR_GO:  w_state_nxt = S_POLL;
      S_POLL: begin
        if (w_done) begin
          w_state_nxt = S_RD_RES;
        end else if (w_timeout) begin
          w_state_nxt = S_CLR_GO;
        end
      end
      S_RD_RES: w_state_nxt = S_CLR_GO;
      S_CLR_GO: w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. Bus values are decoded from the next state and registered,
  // so they are on the bus for exactly the cycle spent in that state.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    rsp_valid   = (r_state == S_RESP);
    w_bus_we    = 1'b0;
    w_bus_addr  = 2'b00;
    w_bus_wdata = '0;
    case (w_state_nxt)
      S_WR_A: begin
        // WR_A is only entered from IDLE, so the operand being accepted is
        // written straight out and A never needs its own holding register.
        w_bus_we    = 1'b1;
        w_bus_addr  = 2'b00;
        w_bus_wdata = req_a;
      end
      S_WR_B: begin
        w_bus_we    = 1'b1;
        w_bus_addr  = 2'b01;
        w_bus_wdata = r_b;
      end
      S_WR_GO: begin
        w_bus_we    = 1'b1;
        w_bus_addr  = 2'b10;
        w_bus_wdata = DATA_W'(1);
      end
      S_RD_RES: begin
        w_bus_addr  = 2'b01;
      end
      S_CLR_GO: begin
        w_bus_we    = 1'b1;
        w_bus_addr  = 2'b10;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 2'b00;
      r_bus_wdata <= '0;
      r_b         <= '0;
      r_rsp_data  <= '0;
      r_poll_cnt  <= '0;
    end else begin
      r_bus_we    <= w_bus_we;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      if ((r_state == S_IDLE) && req_valid) begin
        r_b <= req_b;
      end
      if (r_state == S_RD_RES) begin
        r_rsp_data <= bus_rdata;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
      end
      if (r_state == S_WR_GO) begin
        r_poll_cnt <= '0;
      end else if ((r_state == S_POLL) && !w_done && (r_poll_cnt != '1)) begin
        r_poll_cnt <= r_poll_cnt + CNT_W'(1);
      end
    end
  end

  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_fpmul_bus_master.sv
module tb_fpmul_bus_master;

`ifdef FPMUL_MASTER_TIMEOUT_EN
  localparam int POLL_TO = 8;
`else
  localparam int POLL_TO = 1024;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          done_after;
    int          polls;
    bit          err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q_bus[$];
  exp_t q_rsp[$];
  int   q_acc[$];

  fpmul_bus_master #(
    .DATA_W      (32),
    .POLL_TIMEOUT(POLL_TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no-event", name);
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                              input int done_after, input int polls, input bit err, input int lat);
    exp_t e;
    e.a = a; e.b = b; e.res = res;
    e.done_after = done_after; e.polls = polls; e.err = err; e.lat = lat;
    return e;
  endfunction

  // ---------------- register-bus slave model ----------------
  logic [31:0] s_a, s_b, s_res;
  bit          s_go, s_wa, s_wb;
  int          s_pcnt, s_rd, s_done_after;
  logic        w_done;

  assign w_done = s_go && (s_pcnt >= s_done_after);

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      2'b00:   bus_rdata = {31'b0, w_done};
      2'b10:   bus_rdata = {31'b0, s_go};
      default: bus_rdata = s_res;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      s_go = 0; s_wa = 0; s_wb = 0; s_pcnt = 0; s_rd = 0;
      s_done_after = 0; s_res = '0; s_a = '0; s_b = '0;
    end else begin
      chk("addr_not_11", 32'(bus_addr == 2'b11), 32'd0);
      if (bus_we) begin
        if (s_go) begin
          chk("wr_while_go_addr", 32'(bus_addr), 32'd2);
          chk("wr_while_go_data", bus_wdata, 32'd0);
        end
        if (bus_addr == 2'b00) begin
          s_a = bus_wdata; s_wa = 1;
        end else if (bus_addr == 2'b01) begin
          s_b = bus_wdata; s_wb = 1;
        end else if (bus_addr == 2'b10) begin
          if (bus_wdata == 32'd1 && !s_go) begin
            if (q_bus.size() == 0) begin
              fail_now("go_unexpected");
            end else begin
              chk("go_after_a", 32'(s_wa), 32'd1);
              chk("go_after_b", 32'(s_wb), 32'd1);
              chk("wr_a", s_a, q_bus[0].a);
              chk("wr_b", s_b, q_bus[0].b);
              s_done_after = q_bus[0].done_after;
              s_res        = q_bus[0].res;
            end
            s_go = 1; s_pcnt = 0; s_rd = 0;
          end else if (bus_wdata == 32'd0 && s_go) begin
            if (q_bus.size() == 0) begin
              fail_now("clr_unexpected");
            end else begin
              e = q_bus.pop_front();
              chk("poll_count", 32'(s_pcnt), 32'(e.polls));
              chk("rd_result_count", 32'(s_rd), e.err ? 32'd0 : 32'd1);
            end
            s_go = 0; s_wa = 0; s_wb = 0;
          end else begin
            fail_now("ctrl_write");
          end
        end
      end else if (s_go && bus_addr == 2'b00) begin
        s_pcnt++;
      end else if (s_go && bus_addr == 2'b01) begin
        chk("rd_after_done", 32'(s_pcnt >= s_done_after), 32'd1);
        s_rd++;
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  bit          busy, prev_v, prev_r, prev_e, b2b;
  logic [31:0] prev_d;
  int          hs_edge;

  always @(negedge clk) begin
    exp_t e;
    int   acc;
    if (!rst_n) begin
      busy = 0; prev_v = 0; prev_r = 0; b2b = 0;
      q_acc.delete();
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!busy));
      if (prev_v && !prev_r) begin
        chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
        chk("rsp_data_stable", rsp_data, prev_d);
        chk("rsp_err_stable", 32'(rsp_err), 32'(prev_e));
      end
      if (rsp_valid && !prev_v) begin
        if (q_acc.size() == 0 || q_rsp.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          acc = q_acc.pop_front();
          chk("latency", 32'(cyc - acc), 32'(q_rsp[0].lat));
        end
      end
      if (req_valid && req_ready) begin
        if (b2b) chk("b2b_accept_edge", 32'(cyc + 1), 32'(hs_edge + 1));
        b2b = 0;
        q_acc.push_back(cyc + 1);
        busy = 1;
      end
      if (rsp_valid && rsp_ready) begin
        if (q_rsp.size() == 0) begin
          fail_now("rsp_no_expect");
        end else begin
          e = q_rsp.pop_front();
          chk("rsp_data", rsp_data, e.err ? 32'd0 : e.res);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        hs_edge = cyc + 1;
        b2b     = req_valid;
        busy    = 0;
      end
      prev_v = rsp_valid; prev_r = rsp_ready; prev_d = rsp_data; prev_e = rsp_err;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept();
    bit got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("accept_timeout");
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic send(input exp_t e);
    @(posedge clk);
    #1;
    q_bus.push_back(e);
    q_rsp.push_back(e);
    req_a = e.a; req_b = e.b; req_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_all();
    for (int i = 0; i < 3000; i++) begin
      if (q_rsp.size() == 0) break;
      @(negedge clk);
    end
    if (q_rsp.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic reset_mid(input int edges);
    send(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 1000000, 0, 0, 0));
    repeat (edges) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    q_bus.delete();
    q_rsp.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_bus_we", 32'(bus_we), 32'd0);
  endtask

  exp_t vec[4];

  initial begin
    logic [31:0] ra, rb, rr;
    int          p;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bus_we", 32'(bus_we), 32'd0);
    chk("reset_bus_addr", 32'(bus_addr), 32'd0);
    chk("reset_bus_wdata", bus_wdata, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // directed: 2*3, 1.5*2 (5 polls), -1*4 (2 polls), 0.5*0.5
    vec[0] = mk(32'h40000000, 32'h40400000, 32'h40C00000, 1, 1, 0, 6);
    vec[1] = mk(32'h3FC00000, 32'h40000000, 32'h40400000, 5, 5, 0, 10);
    vec[2] = mk(32'hBF800000, 32'h40800000, 32'hC0800000, 2, 2, 0, 7);
    vec[3] = mk(32'h3F000000, 32'h3F000000, 32'h3E800000, 1, 1, 0, 6);
    for (int i = 0; i < 4; i++) begin
      send(vec[i]);
      wait_all();
    end

    // reset during WR_B and during POLL
    reset_mid(1);
    reset_mid(3);

    // response backpressure with the next request already waiting
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(mk(32'h40400000, 32'h40400000, 32'h41100000, 3, 3, 0, 8));
    begin
      exp_t e2;
      e2 = mk(32'h40800000, 32'h3F000000, 32'h40000000, 1, 1, 0, 6);
      q_bus.push_back(e2);
      q_rsp.push_back(e2);
      req_a = e2.a; req_b = e2.b; req_valid = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_accept();
    wait_all();

`ifdef FPMUL_MASTER_TIMEOUT_EN
    // DONE never arrives: 8 polls, CTRL cleared, error response, then recovery
    send(mk(32'h40000000, 32'h40000000, 32'h12345678, 1000000, 8, 1, 12));
    wait_all();
    send(vec[0]);
    wait_all();
`endif

    // random back-to-back run
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom; rr = $urandom;
      p  = $urandom_range(1, 6);
      send(mk(ra, rb, rr, p, p, 0, 5 + p));
    end
    wait_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
